// File: rtl/alu_md_ctrl.sv
// MIPS EX-stage ALU control decoder with an iterative multiply/divide sequencer and HI/LO registers.
// Optional macro ALU_MD_DIV_EN enables the div/divu path; without it the divider is omitted.
module alu_md_ctrl #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [CTRL_W-1:0] ALUCtrl,
  output logic              md_busy,
  output logic              md_stall,
  output logic              md_rd_valid,
  output logic [DATA_W-1:0] md_rd_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL
`ifdef ALU_MD_DIV_EN
    , S_DIV
`endif
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opb;
  logic                neg_lo;

  logic [3:0]          code;
  logic                is_r, is_mul, is_div, is_mf, is_mt;
  logic                is_signed, sa, sb, last;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next, mul_res;

  always_comb begin
    code = 4'b1111;
    case (ALUOp)
      2'b00: code = 4'b0010;
      2'b01: code = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000: code = 4'b0010;
          6'b100010: code = 4'b0110;
          6'b100100: code = 4'b0000;
          6'b100101: code = 4'b0001;
          6'b100111: code = 4'b1100;
          6'b101010: code = 4'b0111;
          default:   code = 4'b1111;
        endcase
      end
      default: code = 4'b1111;
    endcase
    ALUCtrl = '0;
    ALUCtrl[3:0] = code;
  end

  assign is_r   = (ALUOp == 2'b10);
  assign is_mul = is_r && (funct == 6'b011000 || funct == 6'b011001);
  assign is_mf  = is_r && (funct == 6'b010000 || funct == 6'b010010);
  assign is_mt  = is_r && (funct == 6'b010001 || funct == 6'b010011);
`ifdef ALU_MD_DIV_EN
  assign is_div = is_r && (funct == 6'b011010 || funct == 6'b011011);
`else
  assign is_div = 1'b0;
`endif

  assign md_busy     = (state != S_IDLE);
  assign md_stall    = op_valid && (is_mul || is_div || is_mf || is_mt) && md_busy;
  assign md_rd_valid = op_valid && is_mf && !md_busy;
  assign md_rd_data  = funct[1] ? lo : hi;

  // Signed variants (mult/div) have funct[0]=0; operands are held as magnitudes.
  assign is_signed = ~funct[0];
  assign sa        = is_signed & rs_data[DATA_W-1];
  assign sb        = is_signed & rt_data[DATA_W-1];
  assign a_mag     = sa ? -rs_data : rs_data;
  assign b_mag     = sb ? -rt_data : rt_data;
  assign last      = (cnt == CNT_W'(DATA_W-1));

  // Shift-add: upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  always_comb begin
    mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);
    mul_next = {mul_sum, acc[DATA_W-1:1]};
    mul_res  = neg_lo ? -mul_next : mul_next;
  end

`ifdef ALU_MD_DIV_EN
  logic                neg_hi, div_zero;
  logic [DATA_W:0]     div_shift, div_diff;
  logic [DATA_W-1:0]   div_rem, div_quo, q_res, r_res;

  // Restoring division: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  always_comb begin
    div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (!div_diff[DATA_W]) begin
      div_rem = div_diff[DATA_W-1:0];
      div_quo = {acc[DATA_W-2:0], 1'b1};
    end else begin
      div_rem = div_shift[DATA_W-1:0];
      div_quo = {acc[DATA_W-2:0], 1'b0};
    end
    q_res = div_zero ? '1 : (neg_lo ? -div_quo : div_quo);
    r_res = neg_hi ? -div_rem : div_rem;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      neg_lo <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef ALU_MD_DIV_EN
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid && is_mul) begin
            state  <= S_MUL;
            cnt    <= '0;
            acc    <= {{DATA_W{1'b0}}, a_mag};
            opb    <= b_mag;
            neg_lo <= sa ^ sb;
`ifdef ALU_MD_DIV_EN
          end else if (op_valid && is_div) begin
            state    <= S_DIV;
            cnt      <= '0;
            acc      <= {{DATA_W{1'b0}}, a_mag};
            opb      <= b_mag;
            neg_lo   <= sa ^ sb;
            neg_hi   <= sa;
            div_zero <= (rt_data == '0);
`endif
          end else if (op_valid && is_mt) begin
            if (funct[1]) lo <= rs_data;
            else          hi <= rs_data;
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            hi    <= mul_res[2*DATA_W-1:DATA_W];
            lo    <= mul_res[DATA_W-1:0];
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
`ifdef ALU_MD_DIV_EN
        S_DIV: begin
          acc <= {div_rem, div_quo};
          cnt <= cnt + 1'b1;
          if (last) begin
            hi    <= r_res;
            lo    <= q_res;
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_ctrl.sv
// Directed bench for alu_md_ctrl: decode sweep, mult/div results via a scoreboard queue, stalls, reset, MT/MF.
// Divide checks follow ALU_MD_DIV_EN; without it div must be ignored.
module tb_alu_md_ctrl;
  localparam int W = 32;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         reset, op_valid;
  logic [1:0]   ALUOp;
  logic [5:0]   funct;
  logic [W-1:0] rs_data, rt_data;
  logic [3:0]   ALUCtrl;
  logic         md_busy, md_stall, md_rd_valid;
  logic [W-1:0] md_rd_data, hi, lo;

  int tests = 0;
  int failures = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  alu_md_ctrl #(.DATA_W(W), .CTRL_W(4)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .ALUOp(ALUOp), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .ALUCtrl(ALUCtrl), .md_busy(md_busy),
    .md_stall(md_stall), .md_rd_valid(md_rd_valid), .md_rd_data(md_rd_data),
    .hi(hi), .lo(lo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] f,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid = v;
    ALUOp    = op;
    funct    = f;
    rs_data  = a;
    rt_data  = b;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idleBus();
    applyStimulus(1'b0, 2'b00, 6'b000000, '0, '0);
  endtask

  function automatic logic [63:0] mulModel(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sbv;
    if (sgn) begin
      sa  = $signed({{32{a[31]}}, a});
      sbv = $signed({{32{b[31]}}, b});
      return sa * sbv;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Count busy cycles after the accept edge, then compare HI/LO with the oldest scoreboard entry.
  task automatic waitDone(input string tag);
    int n = 0;
    while (md_busy && n < 200) begin
      n++;
      tick();
    end
    checkOutput({tag, "_busy_cycles"}, 64'(n), 64'(W));
    checkOutput({tag, "_hilo"}, {hi, lo}, sb_q.pop_front());
  endtask

  task automatic runMd(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [63:0] expected);
    sb_q.push_back(expected);
    applyStimulus(1'b1, 2'b10, f, a, b);
    checkOutput({tag, "_accept_stall"}, {63'd0, md_stall}, 64'd0);
    tick();
    idleBus();
    checkOutput({tag, "_busy_after_accept"}, {63'd0, md_busy}, 64'd1);
    waitDone(tag);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [5:0] fts  [7];
    logic [3:0] ctrls[7];
    logic [63:0] hilo_before;
    logic [W-1:0] ra, rb;
    int n;

    fts   = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b000000};
    ctrls = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b1111};

    reset = 1'b1;
    idleBus();
    tick();
    tick();
    checkOutput("reset_busy", {63'd0, md_busy}, 64'd0);
    checkOutput("reset_stall", {63'd0, md_stall}, 64'd0);
    checkOutput("reset_rd_valid", {63'd0, md_rd_valid}, 64'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 2'b10, fts[i], '0, '0);
      checkOutput($sformatf("decode_funct_%0d", i), 64'(ALUCtrl), 64'(ctrls[i]));
    end
    applyStimulus(1'b1, 2'b00, 6'b101010, '0, '0);
    checkOutput("decode_aluop00", 64'(ALUCtrl), 64'h2);
    applyStimulus(1'b1, 2'b01, 6'b100000, '0, '0);
    checkOutput("decode_aluop01", 64'(ALUCtrl), 64'h6);
    applyStimulus(1'b1, 2'b11, 6'b100000, '0, '0);
    checkOutput("decode_aluop11", 64'(ALUCtrl), 64'hF);
    applyStimulus(1'b0, 2'b10, F_MULT, '0, '0);
    checkOutput("decode_mult", 64'(ALUCtrl), 64'hF);
    idleBus();

    runMd("mult_neg2x3", F_MULT, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA);
    runMd("multu_neg2x3", F_MULTU, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      runMd($sformatf("mul_rand_%0d", i), (i % 2 == 0) ? F_MULT : F_MULTU, ra, rb,
            mulModel(i % 2 == 0, ra, rb));
    end

    // mflo presented one cycle after the accepting cycle waits out the remaining 31 busy cycles.
    sb_q.push_back(64'd35);
    applyStimulus(1'b1, 2'b10, F_MULT, 32'd5, 32'd7);
    tick();
    idleBus();
    tick();
    applyStimulus(1'b1, 2'b10, F_MFLO, '0, '0);
    checkOutput("mflo_rd_valid_while_busy", {63'd0, md_rd_valid}, 64'd0);
    n = 0;
    while (md_stall && n < 200) begin
      n++;
      tick();
    end
    checkOutput("mflo_stall_cycles", 64'(n), 64'd31);
    checkOutput("mflo_rd_valid", {63'd0, md_rd_valid}, 64'd1);
    checkOutput("mflo_rd_data", 64'(md_rd_data), 64'd35);
    checkOutput("mflo_hilo", {hi, lo}, sb_q.pop_front());
    idleBus();

    // A second mult issued while busy stalls and starts only once the first has retired.
    sb_q.push_back(64'd12);
    sb_q.push_back(64'd1);
    applyStimulus(1'b1, 2'b10, F_MULT, 32'd3, 32'd4);
    tick();
    applyStimulus(1'b1, 2'b10, F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n = 0;
    while (md_stall && n < 200) begin
      n++;
      tick();
    end
    checkOutput("mult_b_stall_cycles", 64'(n), 64'd32);
    checkOutput("mult_a_hilo", {hi, lo}, sb_q.pop_front());
    tick();
    idleBus();
    checkOutput("mult_b_started", {63'd0, md_busy}, 64'd1);
    waitDone("mult_b");

`ifdef ALU_MD_DIV_EN
    runMd("div_neg7_by_2", F_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
    runMd("div_7_by_0", F_DIV, 32'd7, 32'd0, 64'h00000007_FFFFFFFF);
    runMd("div_minneg_by_m1", F_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    runMd("divu_100_by_7", F_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E);
    applyStimulus(1'b1, 2'b10, F_DIV, 32'd100, 32'd3);
`else
    applyStimulus(1'b1, 2'b10, F_MULT, 32'd100, 32'd3);
`endif
    tick();
    idleBus();
    repeat (10) tick();
    checkOutput("midop_busy", {63'd0, md_busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midop_reset_busy", {63'd0, md_busy}, 64'd0);
    checkOutput("midop_reset_hilo", {hi, lo}, 64'd0);

    applyStimulus(1'b1, 2'b10, F_MTHI, 32'h1234, '0);
    checkOutput("mthi_before_edge", 64'(hi), 64'd0);
    tick();
    checkOutput("mthi_hi", 64'(hi), 64'h1234);
    applyStimulus(1'b0, 2'b10, F_MTLO, 32'h55, '0);
    tick();
    checkOutput("mtlo_invalid_lo", 64'(lo), 64'd0);
    applyStimulus(1'b1, 2'b10, F_MTLO, 32'h55, '0);
    tick();
    checkOutput("mtlo_lo", 64'(lo), 64'h55);
    applyStimulus(1'b1, 2'b10, F_MFHI, '0, '0);
    checkOutput("mfhi_rd_valid", {63'd0, md_rd_valid}, 64'd1);
    checkOutput("mfhi_rd_data", 64'(md_rd_data), 64'h1234);
    applyStimulus(1'b0, 2'b10, F_MFHI, '0, '0);
    checkOutput("mfhi_invalid_rd_valid", {63'd0, md_rd_valid}, 64'd0);

`ifndef ALU_MD_DIV_EN
    hilo_before = {hi, lo};
    applyStimulus(1'b1, 2'b10, F_DIV, 32'd9, 32'd3);
    checkOutput("nodiv_aluctrl", 64'(ALUCtrl), 64'hF);
    checkOutput("nodiv_stall", {63'd0, md_stall}, 64'd0);
    tick();
    checkOutput("nodiv_busy", {63'd0, md_busy}, 64'd0);
    tick();
    idleBus();
    checkOutput("nodiv_hilo", {hi, lo}, hilo_before);
`else
    hilo_before = {hi, lo};
    applyStimulus(1'b1, 2'b10, F_DIV, 32'd9, 32'd3);
    checkOutput("div_aluctrl", 64'(ALUCtrl), 64'hF);
    idleBus();
    checkOutput("div_hilo_untouched", {hi, lo}, hilo_before);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
